// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared types and constants for the 32-entry issue arbiter
package issue_pkg;

    localparam int NUM_REQ = 32;
    localparam int ADDR_W  = 5;

    typedef enum logic {IDLE, HOLD} arb_state_t;

    typedef logic [4:0] rs_idx_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input rs_idx_t idx);
        logic [NUM_REQ-1:0] one;
        one = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/mux32x1.sv
// rtl/mux32x1.sv - 32:1 single-bit multiplexer
module mux32x1 (
    input  logic [31:0] data,
    input  logic [4:0]  sel,
    output logic        y
);

    assign y = data[sel];

endmodule

// File: rtl/rr_pick32.sv
// rtl/rr_pick32.sv - round-robin find-first-set over 32 candidates starting at ptr
module rr_pick32
    import issue_pkg::*;
(
    input  logic [31:0] cand,
    input  rs_idx_t     ptr,
    output logic        found,
    output rs_idx_t     idx
);

    logic [31:0] lo_mask;
    logic [63:0] dbl;

    // Lower copy keeps only bits at or above ptr; the upper copy supplies the wrap.
    always_comb begin
        lo_mask = {32{1'b1}} << ptr;
        dbl     = {cand, cand & lo_mask};
        found   = 1'b0;
        idx     = '0;
        for (int i = 63; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                idx   = i[4:0];
            end
        end
    end

endmodule

// File: rtl/issue_arbiter32.sv
// rtl/issue_arbiter32.sv - round-robin issue arbiter with grant hold, cancel and flush
module issue_arbiter32
    import issue_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               flush,
    input  logic               grant_ready,
    output logic               grant_valid,
    output logic [ADDR_W-1:0]  grant_addr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic               grant_fire
);

    arb_state_t         state, state_n;
    rs_idx_t            ptr, ptr_n;
    rs_idx_t            addr_n;
    logic [NUM_REQ-1:0] onehot_n;

    logic               fire;
    logic               held_req;
    logic [NUM_REQ-1:0] pick_cand;
    rs_idx_t            pick_ptr;
    logic               pick_found;
    rs_idx_t            pick_idx;

    assign grant_valid = (state == HOLD);
    assign fire        = grant_valid & grant_ready & ~flush;
    assign grant_fire  = fire;

    // On a fire the issued entry is masked and the search restarts just past it.
    assign pick_cand = fire ? (req & ~grant_onehot) : req;
    assign pick_ptr  = fire ? (grant_addr + 5'd1) : ptr;

    rr_pick32 u_pick (
        .cand  (pick_cand),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    mux32x1 u_held (
        .data (req),
        .sel  (grant_addr),
        .y    (held_req)
    );

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        addr_n   = grant_addr;
        onehot_n = grant_onehot;
        case (state)
            IDLE: begin
                if (!flush && pick_found) begin
                    state_n  = HOLD;
                    addr_n   = pick_idx;
                    onehot_n = idx_to_onehot(pick_idx);
                end
            end
            HOLD: begin
                if (flush) begin
                    state_n  = IDLE;
                    onehot_n = '0;
                end else if (fire) begin
                    ptr_n = pick_ptr;
                    if (pick_found) begin
                        addr_n   = pick_idx;
                        onehot_n = idx_to_onehot(pick_idx);
                    end else begin
                        state_n  = IDLE;
                        onehot_n = '0;
                    end
                end else if (!held_req) begin
                    // Squashed entry: drop the grant, reselect next cycle from the old ptr.
                    state_n  = IDLE;
                    onehot_n = '0;
                end
            end
            default: begin
                state_n  = IDLE;
                onehot_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_addr   <= '0;
            grant_onehot <= '0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            grant_addr   <= addr_n;
            grant_onehot <= onehot_n;
        end
    end

endmodule

// File: tb/tb_issue_arbiter32.sv
// tb/tb_issue_arbiter32.sv - directed and random checks of issue_arbiter32 against a behavioural model
module tb_issue_arbiter32;

    logic        clk;
    logic        reset;
    logic [31:0] req;
    logic        flush;
    logic        grant_ready;
    logic        grant_valid;
    logic [4:0]  grant_addr;
    logic [31:0] grant_onehot;
    logic        grant_fire;

    int total = 0;
    int bad   = 0;

    bit m_valid;
    int m_addr;
    int m_ptr;

    issue_arbiter32 dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .flush        (flush),
        .grant_ready  (grant_ready),
        .grant_valid  (grant_valid),
        .grant_addr   (grant_addr),
        .grant_onehot (grant_onehot),
        .grant_fire   (grant_fire)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin search written as a plain walk from p upward, wrapping at 32.
    function automatic int model_pick(input logic [31:0] c, input int p);
        for (int k = 0; k < 32; k++) begin
            if (c[(p + k) % 32]) return (p + k) % 32;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, check outputs against the model, then advance the model.
    task automatic step(input logic [31:0] r, input logic f, input logic g, input logic rs);
        bit   fire_e;
        int   p;
        logic [31:0] c;
        req = r; flush = f; grant_ready = g; reset = rs;
        #1;
        fire_e = m_valid && g && !f;
        chk("valid",  {31'b0, grant_valid}, {31'b0, m_valid});
        chk("onehot", grant_onehot, m_valid ? (32'd1 << m_addr) : 32'd0);
        if (m_valid) chk("addr", {27'b0, grant_addr}, m_addr[31:0]);
        chk("fire",   {31'b0, grant_fire}, {31'b0, fire_e});
        chk("ptr",    {27'b0, dut.ptr}, m_ptr[31:0]);
        if (rs) begin
            m_valid = 0; m_addr = 0; m_ptr = 0;
        end else if (!m_valid) begin
            p = model_pick(r, m_ptr);
            if (!f && p >= 0) begin
                m_valid = 1; m_addr = p;
            end
        end else if (f) begin
            m_valid = 0;
        end else if (fire_e) begin
            m_ptr = (m_addr + 1) % 32;
            c = r & ~(32'd1 << m_addr);
            p = model_pick(c, m_ptr);
            if (p >= 0) m_addr = p;
            else        m_valid = 0;
        end else if (!r[m_addr]) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic expect_grant(input string tag, input logic v, input int a);
        #1;
        chk({tag, "_v"}, {31'b0, grant_valid}, {31'b0, v});
        if (v) chk({tag, "_a"}, {27'b0, grant_addr}, a[31:0]);
    endtask

    initial begin
        req = '0; flush = 0; grant_ready = 0; reset = 1;
        m_valid = 0; m_addr = 0; m_ptr = 0;
        @(negedge clk);
        step(32'h0, 0, 0, 1);
        expect_grant("rst", 0, 0);
        chk("rst_addr",   {27'b0, grant_addr}, 32'd0);
        chk("rst_onehot", grant_onehot, 32'd0);

        for (int i = 0; i < 5; i++) step(32'h0, 0, 1, 0);
        expect_grant("idle", 0, 0);
        chk("idle_addr", {27'b0, grant_addr}, 32'd0);

        step(32'h11, 0, 1, 0);
        expect_grant("rr0", 1, 0);
        step(32'h11, 0, 1, 0);
        expect_grant("rr1", 1, 4);
        step(32'h11, 0, 1, 0);
        expect_grant("rr2", 1, 0);
        step(32'h11, 0, 1, 0);
        expect_grant("rr3", 1, 4);

        step(32'h0, 0, 0, 1);
        step(32'h8000_0001, 0, 0, 0);
        expect_grant("wrap0", 1, 0);
        for (int i = 0; i < 3; i++) step(32'h8000_0001, 0, 0, 0);
        expect_grant("stall", 1, 0);
        step(32'h8000_0001, 0, 1, 0);
        expect_grant("wrap31", 1, 31);
        step(32'h8000_0001, 0, 1, 0);
        expect_grant("wrap_back", 1, 0);

        step(32'h0, 0, 0, 1);
        step(32'h80, 0, 0, 0);
        expect_grant("hold7", 1, 7);
        step(32'h200, 0, 0, 0);
        expect_grant("cancel", 0, 0);
        step(32'h200, 0, 0, 0);
        expect_grant("resel9", 1, 9);
        chk("cancel_ptr", {27'b0, dut.ptr}, 32'd0);

        step(32'h0, 0, 0, 1);
        step(32'h8, 0, 0, 0);
        expect_grant("hold3", 1, 3);
        step(32'h8, 1, 1, 0);
        expect_grant("flush", 0, 0);
        step(32'h8, 0, 0, 0);
        expect_grant("reissue3", 1, 3);

        step(32'h0, 0, 0, 1);
        step(32'h1000, 0, 0, 0);
        expect_grant("hold12", 1, 12);
        step(32'hFFFF_FFFF, 0, 0, 1);
        expect_grant("midrst", 0, 0);
        chk("midrst_ptr", {27'b0, dut.ptr}, 32'd0);
        step(32'hFFFF_FFFF, 0, 0, 0);
        expect_grant("after_rst", 1, 0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            case ($urandom_range(0, 3))
                0: r = $urandom & $urandom & $urandom;
                1: r = $urandom;
                2: r = 32'd1 << $urandom_range(0, 31);
                default: r = $urandom & 32'h8000_000F;
            endcase
            step(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
